// File: rtl/hazard_forwarding_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : hazard_forwarding_unit_if                                    |
// | Brief    : Pipeline-side signal bundle for the hazard/forwarding unit.  |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface hazard_forwarding_unit_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_STAGES  = 2,
  parameter int FWD_SEL_W   = 2,
  parameter int STALL_CNT_W = 16
);
  logic [REG_ADDR_W-1:0]            id_ex_rs1;
  logic [REG_ADDR_W-1:0]            id_ex_rs2;
  logic [FWD_STAGES*REG_ADDR_W-1:0] stage_rd;
  logic [FWD_STAGES-1:0]            stage_regwrite;
  logic [REG_ADDR_W-1:0]            id_rs1;
  logic [REG_ADDR_W-1:0]            id_rs2;
  logic [REG_ADDR_W-1:0]            id_rd;
  logic                             id_use_rs1;
  logic                             id_use_rs2;
  logic                             id_regwrite;
  logic                             id_is_long;
  logic                             id_flush;
  logic                             id_ex_memread;
  logic [REG_ADDR_W-1:0]            id_ex_rd;
  logic                             ex_long_issue;
  logic [REG_ADDR_W-1:0]            ex_long_rd;
  logic [FWD_SEL_W-1:0]             forward_a;
  logic [FWD_SEL_W-1:0]             forward_b;
  logic                             stall;
  logic                             bubble;
  logic                             long_busy;
  logic                             long_done;
  logic [REG_ADDR_W-1:0]            long_done_rd;
  logic [STALL_CNT_W-1:0]           stall_count;

  modport master (
    output id_ex_rs1, id_ex_rs2, stage_rd, stage_regwrite,
    output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_regwrite,
    output id_is_long, id_flush, id_ex_memread, id_ex_rd,
    output ex_long_issue, ex_long_rd,
    input  forward_a, forward_b, stall, bubble,
    input  long_busy, long_done, long_done_rd, stall_count
  );

  modport slave (
    input  id_ex_rs1, id_ex_rs2, stage_rd, stage_regwrite,
    input  id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_regwrite,
    input  id_is_long, id_flush, id_ex_memread, id_ex_rd,
    input  ex_long_issue, ex_long_rd,
    output forward_a, forward_b, stall, bubble,
    output long_busy, long_done, long_done_rd, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_forwarding_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : hazard_forwarding_unit                                       |
// | Brief    : N-stage operand forwarding, load-use stall and a single-     |
// |            entry scoreboard for the non-pipelined MUL/DIV unit.         |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module hazard_forwarding_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_STAGES  = 2,
  parameter int FWD_SEL_W   = 2,
  parameter int LONG_LAT    = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hazard_forwarding_unit_if.slave bus
);
  localparam int c_CNT_W = 4;

  logic                   r_busy;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [REG_ADDR_W-1:0]  r_lrd;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic [FWD_SEL_W-1:0]   w_fwd_a;
  logic [FWD_SEL_W-1:0]   w_fwd_b;
  logic                   w_load_use;
  logic                   w_lrd_live;
  logic                   w_raw;
  logic                   w_waw;
  logic                   w_struct;
  logic                   w_stall;
  logic                   w_done;

  // Walk oldest to youngest so the lowest matching index is the last writer.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (bus.stage_regwrite[i] && (bus.stage_rd[i*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
        if (bus.stage_rd[i*REG_ADDR_W +: REG_ADDR_W] == bus.id_ex_rs1)
          w_fwd_a = FWD_SEL_W'(i + 1);
        if (bus.stage_rd[i*REG_ADDR_W +: REG_ADDR_W] == bus.id_ex_rs2)
          w_fwd_b = FWD_SEL_W'(i + 1);
      end
    end
  end

  assign w_load_use = bus.id_ex_memread && (bus.id_ex_rd != '0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.id_ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.id_ex_rd)));

  assign w_lrd_live = r_busy && (r_lrd != '0);
  assign w_raw      = w_lrd_live &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == r_lrd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == r_lrd)));
  assign w_waw      = w_lrd_live && bus.id_regwrite && (bus.id_rd == r_lrd);
  assign w_struct   = r_busy && bus.id_is_long;
  assign w_done     = r_busy && (r_cnt == c_CNT_W'(1));

  // A flushed decode slot must never hold the pipe.
  assign w_stall = !bus.id_flush && (w_load_use || w_raw || w_waw || w_struct);

  // A same-edge issue takes priority over completion so back-to-back ops chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_lrd  <= '0;
    end else if (bus.ex_long_issue) begin
      r_busy <= 1'b1;
      r_cnt  <= c_CNT_W'(LONG_LAT);
      r_lrd  <= bus.ex_long_rd;
    end else if (r_busy) begin
      if (w_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt - c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign bus.forward_a    = w_fwd_a;
  assign bus.forward_b    = w_fwd_b;
  assign bus.stall        = w_stall;
  assign bus.bubble       = w_stall;
  assign bus.long_busy    = r_busy;
  assign bus.long_done    = w_done;
  assign bus.long_done_rd = r_lrd;
  assign bus.stall_count  = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_forwarding_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_hazard_forwarding_unit                                    |
// | Brief    : Directed self-checking bench for hazard_forwarding_unit.     |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_hazard_forwarding_unit;
  localparam int REG_ADDR_W  = 5;
  localparam int FWD_STAGES  = 2;
  localparam int FWD_SEL_W   = 2;
  localparam int LONG_LAT    = 4;
  // Narrow counter so saturation is reachable in a short run.
  localparam int STALL_CNT_W = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_forwarding_unit_if #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .FWD_SEL_W  (FWD_SEL_W),
    .STALL_CNT_W(STALL_CNT_W)
  ) bus ();

  hazard_forwarding_unit #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .FWD_SEL_W  (FWD_SEL_W),
    .LONG_LAT   (LONG_LAT),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_id();
    bus.id_rs1        = '0;
    bus.id_rs2        = '0;
    bus.id_rd         = '0;
    bus.id_use_rs1    = 1'b0;
    bus.id_use_rs2    = 1'b0;
    bus.id_regwrite   = 1'b0;
    bus.id_is_long    = 1'b0;
    bus.id_flush      = 1'b0;
    bus.id_ex_memread = 1'b0;
    bus.id_ex_rd      = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.id_ex_rs1      = '0;
    bus.id_ex_rs2      = '0;
    bus.stage_rd       = '0;
    bus.stage_regwrite = '0;
    bus.ex_long_issue  = 1'b0;
    bus.ex_long_rd     = '0;
    clear_id();

    // Reset state
    #12;
    check("rst_busy", 32'(bus.long_busy), 32'd0);
    check("rst_done", 32'(bus.long_done), 32'd0);
    check("rst_done_rd", 32'(bus.long_done_rd), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_count), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Forwarding select
    bus.stage_rd       = {5'd5, 5'd2};
    bus.stage_regwrite = 2'b11;
    bus.id_ex_rs1      = 5'd2;
    bus.id_ex_rs2      = 5'd5;
    #1;
    check("fwd_a_stage0", 32'(bus.forward_a), 32'd1);
    check("fwd_b_stage1", 32'(bus.forward_b), 32'd2);
    bus.stage_rd = {5'd2, 5'd2};
    #1;
    check("fwd_a_youngest", 32'(bus.forward_a), 32'd1);
    check("fwd_b_nomatch", 32'(bus.forward_b), 32'd0);
    bus.stage_regwrite = 2'b10;
    #1;
    check("fwd_a_older_only", 32'(bus.forward_a), 32'd2);
    bus.stage_rd       = '0;
    bus.stage_regwrite = 2'b11;
    bus.id_ex_rs1      = '0;
    bus.id_ex_rs2      = '0;
    #1;
    check("fwd_a_x0", 32'(bus.forward_a), 32'd0);
    check("fwd_b_x0", 32'(bus.forward_b), 32'd0);

    // Load-use; one stalled edge bumps the counter to 1
    @(negedge clk);
    bus.id_ex_memread = 1'b1;
    bus.id_ex_rd      = 5'd7;
    bus.id_rs2        = 5'd7;
    bus.id_use_rs2    = 1'b1;
    #1;
    check("lu_stall", 32'(bus.stall), 32'd1);
    check("lu_bubble", 32'(bus.bubble), 32'd1);
    tick();
    check("lu_count", 32'(bus.stall_count), 32'd1);
    bus.id_use_rs2 = 1'b0;
    #1;
    check("lu_unused_rs2", 32'(bus.stall), 32'd0);
    bus.id_use_rs2 = 1'b1;
    bus.id_flush   = 1'b1;
    #1;
    check("lu_flush_stall", 32'(bus.stall), 32'd0);
    check("lu_flush_bubble", 32'(bus.bubble), 32'd0);
    bus.id_flush = 1'b0;
    bus.id_ex_rd = '0;
    bus.id_rs2   = '0;
    #1;
    check("lu_rd_x0", 32'(bus.stall), 32'd0);
    clear_id();
    tick();
    check("lu_count_hold", 32'(bus.stall_count), 32'd1);

    // Long op rd=9 with a dependent reader held in decode
    bus.ex_long_issue = 1'b1;
    bus.ex_long_rd    = 5'd9;
    bus.id_rs1        = 5'd9;
    bus.id_use_rs1    = 1'b1;
    #1;
    check("long_pre_busy", 32'(bus.long_busy), 32'd0);
    check("long_pre_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.ex_long_issue = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("long_busy", 32'(bus.long_busy), 32'd1);
      check("long_done", 32'(bus.long_done), (k == 4) ? 32'd1 : 32'd0);
      check("long_raw_stall", 32'(bus.stall), 32'd1);
      if (k == 4) check("long_done_rd", 32'(bus.long_done_rd), 32'd9);
      tick();
    end
    check("long_after_busy", 32'(bus.long_busy), 32'd0);
    check("long_after_done", 32'(bus.long_done), 32'd0);
    check("long_after_stall", 32'(bus.stall), 32'd0);
    check("long_stall_count", 32'(bus.stall_count), 32'd5);
    clear_id();

    // Scoreboard with lrd=3: structural, WAW, RAW
    bus.ex_long_issue = 1'b1;
    bus.ex_long_rd    = 5'd3;
    tick();
    bus.ex_long_issue = 1'b0;
    bus.id_is_long    = 1'b1;
    bus.id_rd         = 5'd4;
    #1;
    check("sb_struct", 32'(bus.stall), 32'd1);
    bus.id_is_long  = 1'b0;
    bus.id_regwrite = 1'b1;
    bus.id_rd       = 5'd3;
    #1;
    check("sb_waw", 32'(bus.stall), 32'd1);
    bus.id_regwrite = 1'b0;
    bus.id_use_rs2  = 1'b1;
    bus.id_rs2      = 5'd3;
    #1;
    check("sb_raw_rs2", 32'(bus.stall), 32'd1);
    bus.id_rs2 = 5'd4;
    #1;
    check("sb_no_hazard", 32'(bus.stall), 32'd0);
    clear_id();
    tick();
    tick();
    tick();
    check("sb_done", 32'(bus.long_done), 32'd1);
    check("sb_done_rd", 32'(bus.long_done_rd), 32'd3);

    // Re-issue with rd=0 on the completion edge; new issue wins
    bus.ex_long_issue = 1'b1;
    bus.ex_long_rd    = '0;
    tick();
    bus.ex_long_issue = 1'b0;
    #1;
    check("chain_busy", 32'(bus.long_busy), 32'd1);
    check("chain_done", 32'(bus.long_done), 32'd0);
    bus.id_rs1     = '0;
    bus.id_use_rs1 = 1'b1;
    #1;
    check("x0_no_raw", 32'(bus.stall), 32'd0);
    bus.id_regwrite = 1'b1;
    bus.id_rd       = '0;
    #1;
    check("x0_no_waw", 32'(bus.stall), 32'd0);
    bus.id_is_long = 1'b1;
    #1;
    check("x0_struct", 32'(bus.stall), 32'd1);
    clear_id();
    tick();

    // Async reset mid-countdown
    check("mid_busy", 32'(bus.long_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.long_busy), 32'd0);
    check("arst_done", 32'(bus.long_done), 32'd0);
    check("arst_done_rd", 32'(bus.long_done_rd), 32'd0);
    check("arst_count", 32'(bus.stall_count), 32'd0);

    // Saturation of the 4-bit stall counter
    @(negedge clk);
    rst_n             = 1'b1;
    bus.id_ex_memread = 1'b1;
    bus.id_ex_rd      = 5'd7;
    bus.id_rs1        = 5'd7;
    bus.id_use_rs1    = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("sat_14", 32'(bus.stall_count), 32'd14);
    tick();
    check("sat_15", 32'(bus.stall_count), 32'd15);
    repeat (5) tick();
    check("sat_hold", 32'(bus.stall_count), 32'd15);
    clear_id();
    tick();
    check("sat_idle", 32'(bus.stall_count), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
